// File: rtl/dense_input_sequencer.sv
// Walks input neurons 0..INPUT_NEURONS-1, pairing each activation with its weight row for the MAC array.
// Optional macro SEQ_STALL_COUNT_EN adds a saturating backpressure counter on stall_cycles.
module dense_input_sequencer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned INPUT_NEURONS  = 100,
    parameter int unsigned OUTPUT_NEURONS = 32,
    parameter int unsigned ADDR_WIDTH     = 9
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [DATA_WIDTH*INPUT_NEURONS-1:0]  in_data,
    output logic [ADDR_WIDTH-1:0]                address,
    input  logic [DATA_WIDTH*OUTPUT_NEURONS-1:0] weights,
    output logic                                 mac_valid,
    input  logic                                 mac_ready,
    output logic [DATA_WIDTH-1:0]                mac_input,
    output logic [DATA_WIDTH*OUTPUT_NEURONS-1:0] mac_weights,
    output logic                                 mac_first,
    output logic                                 mac_last,
    output logic                                 busy,
    output logic                                 done
`ifdef SEQ_STALL_COUNT_EN
    ,
    output logic [15:0]                          stall_cycles
`endif
);

    localparam int unsigned VEC_W = DATA_WIDTH * INPUT_NEURONS;
    localparam logic [ADDR_WIDTH-1:0] IDLE_ADDR = ADDR_WIDTH'(INPUT_NEURONS);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(INPUT_NEURONS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   index_q, index_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [VEC_W-1:0]        vec_q, vec_d;
    logic                    mac_valid_q, mac_valid_d;
    logic [DATA_WIDTH-1:0]   mac_input_q, mac_input_d;
    logic                    mac_first_q, mac_first_d;
    logic                    mac_last_q, mac_last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   word_sel;
    logic                    handshake;

    // Activation select: word k lives at the MSB end of the packed vector.
    always_comb begin
        word_sel = '0;
        for (int k = 0; k < int'(INPUT_NEURONS); k++) begin
            if (index_q == ADDR_WIDTH'(k)) begin
                word_sel = vec_q[(INPUT_NEURONS-1-k)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign handshake = mac_valid_q & mac_ready;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        address_d   = address_q;
        vec_d       = vec_q;
        mac_valid_d = mac_valid_q;
        mac_input_d = mac_input_q;
        mac_first_d = mac_first_q;
        mac_last_d  = mac_last_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                address_d = IDLE_ADDR;
                if (start) begin
                    vec_d     = in_data;
                    index_d   = '0;
                    address_d = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d     = S_PRESENT;
                mac_valid_d = 1'b1;
                mac_input_d = word_sel;
                mac_first_d = (index_q == '0);
                mac_last_d  = (index_q == LAST_IDX);
            end
            S_PRESENT: begin
                if (handshake) begin
                    mac_valid_d = 1'b0;
                    mac_input_d = '0;
                    mac_first_d = 1'b0;
                    mac_last_d  = 1'b0;
                    if (mac_last_q) begin
                        state_d   = S_IDLE;
                        address_d = IDLE_ADDR;
                        done_d    = 1'b1;
                    end else begin
                        index_d   = index_q + ADDR_WIDTH'(1);
                        address_d = index_q + ADDR_WIDTH'(1);
                        state_d   = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            address_q   <= IDLE_ADDR;
            vec_q       <= '0;
            mac_valid_q <= 1'b0;
            mac_input_q <= '0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            address_q   <= address_d;
            vec_q       <= vec_d;
            mac_valid_q <= mac_valid_d;
            mac_input_q <= mac_input_d;
            mac_first_q <= mac_first_d;
            mac_last_q  <= mac_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign address     = address_q;
    assign mac_valid   = mac_valid_q;
    assign mac_input   = mac_input_q;
    assign mac_weights = weights;
    assign mac_first   = mac_first_q;
    assign mac_last    = mac_last_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef SEQ_STALL_COUNT_EN
    logic [15:0] stall_q, stall_d;

    // Backpressure counter: cleared when a pass is accepted, saturating.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && start) begin
            stall_d = '0;
        end else if (mac_valid_q && !mac_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_dense_input_sequencer.sv
// Scoreboard bench for dense_input_sequencer: randomized passes, backpressure, mid-pass reset, 1-neuron build.
module tb_dense_input_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned N  = 100;
    localparam int unsigned ON = 32;
    localparam int unsigned AW = 9;
    localparam int unsigned WW = DW * ON;

    logic              clk;
    logic              reset;
    logic              start;
    logic [DW*N-1:0]   in_data;
    logic [AW-1:0]     address;
    logic [WW-1:0]     weights;
    logic              mac_valid;
    logic              mac_ready;
    logic [DW-1:0]     mac_input;
    logic [WW-1:0]     mac_weights;
    logic              mac_first;
    logic              mac_last;
    logic              busy;
    logic              done;
`ifdef SEQ_STALL_COUNT_EN
    logic [15:0]       stall_cycles;
    logic [15:0]       stall1;
`endif

    // Single-neuron instance.
    logic              start1;
    logic [DW-1:0]     in_data1;
    logic [0:0]        address1;
    logic [2*DW-1:0]   weights1;
    logic              valid1, ready1, first1, last1, busy1, done1;
    logic [DW-1:0]     input1;
    logic [2*DW-1:0]   mweights1;

    dense_input_sequencer #(.DATA_WIDTH(DW), .INPUT_NEURONS(N), .OUTPUT_NEURONS(ON), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .address(address),
        .weights(weights), .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_input(mac_input),
        .mac_weights(mac_weights), .mac_first(mac_first), .mac_last(mac_last), .busy(busy), .done(done)
`ifdef SEQ_STALL_COUNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    dense_input_sequencer #(.DATA_WIDTH(DW), .INPUT_NEURONS(1), .OUTPUT_NEURONS(2), .ADDR_WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .in_data(in_data1), .address(address1),
        .weights(weights1), .mac_valid(valid1), .mac_ready(ready1), .mac_input(input1),
        .mac_weights(mweights1), .mac_first(first1), .mac_last(last1), .busy(busy1), .done(done1)
`ifdef SEQ_STALL_COUNT_EN
        , .stall_cycles(stall1)
`endif
    );

    typedef struct {
        int            idx;
        logic [DW-1:0] word;
        int            earliest;
    } item_t;

    item_t q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    bit    model_busy = 0;
    int    start_cyc = -10;
    int    model_stalls = 0;
    int    stalls_at_done = 0;
    bit    exp_done_next = 0;
    int    ign_start_cyc = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Row r of weight memory holds r*ON+i in word i; out-of-range rows read as zero.
    function automatic logic [WW-1:0] row_of(input int r);
        logic [WW-1:0] w = '0;
        if (r >= 0 && r < int'(N)) begin
            for (int i = 0; i < int'(ON); i++) w[(int'(ON)-1-i)*int'(DW) +: DW] = DW'(r * int'(ON) + i);
        end
        return w;
    endfunction

    always @(posedge clk) weights  <= row_of(int'(address));
    always @(posedge clk) weights1 <= (address1 == 1'b0) ? {32'hA5A5_0001, 32'h5A5A_0002} : '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_w(input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < int'(ON); i++) begin
                if (act[(int'(ON)-1-i)*int'(DW) +: DW] !== exp[(int'(ON)-1-i)*int'(DW) +: DW]) begin
                    $display("FAIL mac_weights word %0d: got %0h expected %0h (cycle %0d)", i,
                             act[(int'(ON)-1-i)*int'(DW) +: DW], exp[(int'(ON)-1-i)*int'(DW) +: DW], cyc);
                    break;
                end
            end
        end
    endtask

    function automatic bit presenting(input int k);
        return model_busy && q.size() > 0 && q[0].idx == k && cyc >= q[0].earliest;
    endfunction

    // Reference model: an accepted start queues every index of the pass.
    task automatic accept();
        if (start && !model_busy && !reset) begin
            model_busy   = 1;
            start_cyc    = cyc;
            model_stalls = 0;
            for (int k = 0; k < int'(N); k++) begin
                item_t it;
                it.idx      = k;
                it.word     = in_data[(int'(N)-1-k)*int'(DW) +: DW];
                it.earliest = (k == 0) ? cyc + 2 : 0;
                q.push_back(it);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_vec();
        for (int k = 0; k < int'(N); k++) in_data[k*int'(DW) +: DW] = $urandom;
    endtask

    // Monitor: compares DUT against the head of the scoreboard every cycle.
    always @(negedge clk) begin
        bit ev;
        bit done_now;
        if (!reset) begin
            done_now      = exp_done_next;
            exp_done_next = 0;
            ev = model_busy && q.size() > 0 && cyc >= q[0].earliest;
            chk("mac_valid", 64'(mac_valid), 64'(ev));
            chk("busy", 64'(busy), 64'(model_busy && cyc > start_cyc));
            if (done || done_now) chk("done", 64'(done), 64'(done_now));
`ifdef SEQ_STALL_COUNT_EN
            if (done_now) chk("stall_cycles", 64'(stall_cycles), 64'(stalls_at_done));
`endif
            if (ev) begin
                chk("address", 64'(address), 64'(q[0].idx));
                chk("mac_input", 64'(mac_input), 64'(q[0].word));
                chk("mac_first", 64'(mac_first), 64'(q[0].idx == 0));
                chk("mac_last", 64'(mac_last), 64'(q[0].idx == int'(N) - 1));
                chk_w(mac_weights, row_of(q[0].idx));
                if (!mac_ready) begin
                    model_stalls++;
                end else if (q[0].idx == int'(N) - 1) begin
                    void'(q.pop_front());
                    model_busy     = 0;
                    exp_done_next  = 1;
                    stalls_at_done = model_stalls;
                end else begin
                    void'(q.pop_front());
                    q[0].earliest = cyc + 2;
                end
            end else begin
                if (!mac_valid) begin
                    chk("idle mac_input", 64'(mac_input), 64'd0);
                    chk("idle mac_first", 64'(mac_first), 64'd0);
                    chk("idle mac_last", 64'(mac_last), 64'd0);
                end
                if (model_busy && cyc > start_cyc && q.size() > 0)
                    chk("fetch address", 64'(address), 64'(q[0].idx));
                else
                    chk("idle address", 64'(address), 64'(N));
            end
        end
    end

    // Run until the model reports the pass complete; returns in the done cycle.
    task automatic run_pass(input int mode);
        int n = 0;
        int stalled = 0;
        while (1) begin
            step();
            if (!model_busy) break;
            n++;
            if (n > 4 * int'(N) + 50) begin
                checks++;
                errors++;
                $display("FAIL pass_timeout: got %0d cycles required at most %0d", n, 4 * int'(N) + 50);
                break;
            end
            start = (mode == 2) ? ($urandom_range(0, 7) == 0) : (cyc == ign_start_cyc);
            case (mode)
                1: begin
                    if (presenting(5) && stalled < 3) begin
                        mac_ready = 1'b0;
                        stalled++;
                    end else begin
                        mac_ready = 1'b1;
                    end
                end
                2:       mac_ready = ($urandom_range(0, 3) != 0);
                default: mac_ready = 1'b1;
            endcase
            accept();
        end
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; mac_ready = 1'b0; in_data = '0;
        start1 = 1'b0; ready1 = 1'b1; in_data1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst address", 64'(address), 64'(N));
        chk("rst mac_valid", 64'(mac_valid), 64'd0);
        chk("rst mac_first", 64'(mac_first), 64'd0);
        chk("rst mac_last", 64'(mac_last), 64'd0);
        chk("rst mac_input", 64'(mac_input), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk_w(mac_weights, '0);
        step();
        reset = 1'b0;
        step();

        // Pass A: word k = k+1, ready high, stray start at cycle 50.
        for (int k = 0; k < int'(N); k++) in_data[(int'(N)-1-k)*int'(DW) +: DW] = DW'(k + 1);
        start = 1'b1; mac_ready = 1'b1; accept();
        ign_start_cyc = cyc + 50;
        run_pass(0);

        // Pass B accepted in the done cycle, with 3-cycle stall at index 5.
        rand_vec(); start = 1'b1; mac_ready = 1'b1; accept();
        run_pass(1);

        for (int p = 0; p < 2; p++) begin
            rand_vec(); start = 1'b1; mac_ready = 1'b1; accept();
            run_pass(2);
        end

        // Reset while index 40 is presented.
        rand_vec(); start = 1'b1; mac_ready = 1'b1; accept();
        n = 0;
        while (1) begin
            step();
            start = 1'b0;
            n++;
            if (presenting(40)) begin
                reset = 1'b1;
                q.delete();
                model_busy    = 0;
                exp_done_next = 0;
                break;
            end
            if (n > 4 * int'(N)) begin
                checks++;
                errors++;
                $display("FAIL reset_wait: got %0d cycles required at most %0d", n, 4 * int'(N));
                break;
            end
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset address", 64'(address), 64'(N));
        chk("post-reset mac_valid", 64'(mac_valid), 64'd0);
        chk("post-reset busy", 64'(busy), 64'd0);
        chk("post-reset done", 64'(done), 64'd0);
        step();
        rand_vec(); start = 1'b1; mac_ready = 1'b1; accept();
        run_pass(2);
        mac_ready = 1'b1;

        // Single-neuron build: first and last together, done next cycle.
        step();
        in_data1 = $urandom;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        @(negedge clk);
        chk("n1 fetch busy", 64'(busy1), 64'd1);
        chk("n1 fetch valid", 64'(valid1), 64'd0);
        chk("n1 fetch address", 64'(address1), 64'd0);
        step();
        @(negedge clk);
        chk("n1 valid", 64'(valid1), 64'd1);
        chk("n1 first", 64'(first1), 64'd1);
        chk("n1 last", 64'(last1), 64'd1);
        chk("n1 input", 64'(input1), 64'(in_data1));
        chk("n1 weights", 64'(mweights1), {32'hA5A5_0001, 32'h5A5A_0002});
        step();
        @(negedge clk);
        chk("n1 done", 64'(done1), 64'd1);
        chk("n1 valid after", 64'(valid1), 64'd0);
        chk("n1 busy after", 64'(busy1), 64'd0);
        chk("n1 address after", 64'(address1), 64'd1);
        step();
        @(negedge clk);
        chk("n1 done pulse", 64'(done1), 64'd0);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dense_input_sequencer.md
Name: dense_input_sequencer

Overview:
- Drives the weight memory's row address and walks input neurons 0..INPUT_NEURONS-1 for one fully-connected layer pass.
- For each index it presents one input activation together with the matching weight row (OUTPUT_NEURONS packed IEEE-754 words) to the downstream MAC array.
- Uses a valid/ready handshake and first/last strobes.
- Sits between the previous layer's output vector and the weight memory / MAC array.

Parameters:
- DATA_WIDTH, 32, bits per activation/weight word (IEEE-754 single).
- INPUT_NEURONS, 100, number of input activations (rows in weight memory).
- OUTPUT_NEURONS, 32, weights per row (words per memory read).
- ADDR_WIDTH, 9, width of memory address; must satisfy 2^ADDR_WIDTH > INPUT_NEURONS.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a pass; sampled only in IDLE.
- in_data  input  DATA_WIDTH*INPUT_NEURONS  input vector; word k at [(INPUT_NEURONS-1-k)*DATA_WIDTH +: DATA_WIDTH]; captured on accepted start.
- address  output  ADDR_WIDTH  row address to weight memory (registered).
- weights  input  DATA_WIDTH*OUTPUT_NEURONS  weight row from memory; valid one clock after address changes, held while address is stable.
- mac_valid  output  1  mac_* payload valid.
- mac_ready  input  1  downstream accepts payload.
- mac_input  output  DATA_WIDTH  activation for current index.
- mac_weights  output  DATA_WIDTH*OUTPUT_NEURONS  weight row for current index.
- mac_first  output  1  current index is 0 (accumulators clear).
- mac_last  output  1  current index is INPUT_NEURONS-1.
- busy  output  1  pass in progress.
- done  output  1  one-cycle pulse after final handshake.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: address=INPUT_NEURONS (out of range, so memory returns 0); mac_valid=0; mac_first=0; mac_last=0; busy=0; done=0; mac_input=0; index=0; state=IDLE.
- Reset mid-pass aborts immediately; no done pulse is issued.
- FSM states: IDLE, FETCH, PRESENT.
- IDLE:
  - address=INPUT_NEURONS.
  - start=1 latches in_data into the internal vector, sets index=0 and goes to FETCH.
  - start while not IDLE is ignored.
- FETCH:
  - address=index, registered on entry.
  - One cycle wait for memory latency, then PRESENT.
- PRESENT:
  - mac_valid=1.
  - mac_input=latched word[index].
  - mac_weights=weights (combinational pass-through).
  - mac_first=(index==0); mac_last=(index==INPUT_NEURONS-1).
  - address held at index, so the payload is stable under backpressure.
  - Handshake occurs on mac_valid & mac_ready.
    - Not last: index+1, address=index+1, go to FETCH.
    - Last: go to IDLE, address=INPUT_NEURONS, done=1 for exactly one cycle.
- busy = (state != IDLE).
- When mac_valid=0: mac_input=0, mac_first=0, mac_last=0. mac_weights follows memory output, which is don't-care.
- Timing with start accepted at cycle 0 and ready held high:
  - FETCH at cycle 1; first valid at cycle 2.
  - Index k is valid at cycle 2+2k.
  - Last handshake at cycle 2*INPUT_NEURONS; done at cycle 2*INPUT_NEURONS+1.
- Throughput: one index per 2 cycles with no stall. Each mac_ready=0 cycle during PRESENT adds one cycle.
- A start coinciding with the done cycle (IDLE) is accepted.
- INPUT_NEURONS=1: mac_first and mac_last are asserted together.
- index and address never exceed INPUT_NEURONS-1 while busy.

Optional Feature:
- Macro: SEQ_STALL_COUNT_EN.
- Defined:
  - Adds output stall_cycles [15:0].
  - Counts cycles with mac_valid=1 & mac_ready=0; saturates at 16'hFFFF.
  - Cleared to 0 by reset and by an accepted start; holds its value after the pass.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults, reset, then start at cycle 0 with in_data word k=k+1 and mac_ready=1:
  - 100 handshakes at cycles 2,4,…,200 with mac_input=1..100.
  - address 0..99; mac_first only at cycle 2; mac_last only at cycle 200; done at cycle 201; busy=0 at 201.
- mac_ready=0 for 3 cycles at index 5:
  - mac_valid, mac_input, address=5 and mac_weights stay stable.
  - Handshake completes on the 4th cycle; done is delayed by 3 cycles.
  - With SEQ_STALL_COUNT_EN, stall_cycles=3.
- start pulsed again at cycle 50 while busy: ignored, sequence unchanged. start at cycle 201 (done cycle): new pass begins, first valid at cycle 203.
- reset asserted at index 40:
  - Next cycle: address=100, mac_valid=0, busy=0; no done pulse.
  - A subsequent start restarts at index 0.
- Weight memory model with row r filled with r*OUTPUT_NEURONS+i: each handshake's mac_weights matches row=index, word i at [(OUTPUT_NEURONS-1-i)*DATA_WIDTH +: DATA_WIDTH]. Idle address=INPUT_NEURONS yields an all-zero memory output.
- INPUT_NEURONS=1 build: one handshake with mac_first=mac_last=1, then done the next cycle.
